mem_store_ctrl: RTL and testbench
=================================

// Module: mem_store_ctrl
// PURPOSE
//   Write-side counterpart of the multi-cycle CPU's memory data register path.
//   Registers one store request (address, data, size) from the control unit.
//   Aligns the data to byte lanes and generates byte enables.
//   Drives a req/ack memory write handshake and reports completion back to the FSM.
// PARAMETERS
//   ADDR_W    32  width of st_addr / mem_addr
//   TIMEOUT   16  max cycles to wait for mem_ack; used only with STORE_TIMEOUT_EN; must be >=2
// PORTS
//   clk           in   1       system clock, rising edge
//   rst_n         in   1       synchronous reset, active-low
//   st_req        in   1       store request from control unit, sampled only in IDLE
//   st_addr       in   ADDR_W  byte address
//   st_data       in   32      store data, right-justified
//   st_size       in   2       00=byte 01=half 10=word 11=reserved
//   st_busy       out  1       high whenever state != IDLE
//   st_done       out  1       one-cycle completion pulse
//   st_misalign   out  1       valid with st_done: access rejected, no memory write
//   st_err        out  1       valid with st_done: timeout abort (0 without macro)
//   mem_wr_req    out  1       memory write request
//   mem_addr      out  ADDR_W  word address {st_addr[ADDR_W-1:2],2'b00}
//   mem_wdata     out  32      lane-replicated write data
//   mem_be        out  4       byte enables, bit i = byte lane i (bits [8i+7:8i])
//   mem_ack       in   1       memory accepted write, sampled on clk
// BEHAVIOUR
// - States: IDLE -> REQ -> DONE -> IDLE; IDLE -> FAIL -> IDLE.
// - Reset (rst_n=0 at an edge): state=IDLE. All outputs 0, including mem_addr/mem_wdata/mem_be.
// - Reset mid-operation: mem_wr_req drops at that edge; no st_done is produced.
// - IDLE, st_req=1: capture addr/data/size into registers at the edge.
//   - Legal access: next state REQ.
//   - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11: next state FAIL.
// - REQ: mem_wr_req=1; mem_addr, mem_wdata, mem_be come from registers and are held stable.
//   - Stays in REQ until mem_ack=1 is sampled, then goes to DONE.
// - DONE: st_done=1 for one cycle, mem_wr_req=0, then IDLE.
// - FAIL: st_done=1 and st_misalign=1 for one cycle; mem_wr_req stays 0; then IDLE.
// - Latency: request accepted at edge N -> mem_wr_req high from N+1.
//   - Zero-wait ack: sampled at N+2, st_done high in cycle N+2..N+3.
//   - Best-case turnaround: 3 cycles, accept to back in IDLE.
// - Lane rules:
//   - byte: wdata = {4{d[7:0]}},  be = 4'b0001 << addr[1:0]
//   - half: wdata = {2{d[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011
//   - word: wdata = d,            be = 4'b1111
// - st_req while busy: ignored (not queued). mem_ack outside REQ: ignored.
// - st_req in the DONE/FAIL cycle: ignored. The next request is accepted only in IDLE.
// - st_misalign and st_err are 0 whenever st_done=0.
// CONFIGURATION
// - STORE_TIMEOUT_EN defined:
//   - Counter clears on entry to REQ and increments each cycle spent in REQ.
//   - If TIMEOUT cycles pass without mem_ack: drop mem_wr_req, go to DONE.
//   - That DONE cycle pulses st_done=1 with st_err=1.
//   - If mem_ack arrives in the same cycle the count expires, ack wins: st_err=0.
// - STORE_TIMEOUT_EN undefined: no counter logic; st_err tied 0; REQ waits indefinitely.
// TESTING
// - Word store: addr=0x100, d=0xDEADBEEF, size=10, ack after 3 cycles.
//   -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF held stable all REQ cycles; one st_done.
// - Byte store: addr=0x203, d=0x000000A5, size=00, immediate ack.
//   -> mem_addr=0x200, be=1000, wdata=0xA5A5A5A5; st_done 2 cycles after accept.
// - Misaligned: half at 0x101, then word at 0x102.
//   -> each gives st_done+st_misalign, mem_wr_req never asserted.
// - Busy overlap: second st_req (d=0x11111111) while in REQ.
//   -> ignored; only the first transaction's data reaches memory.
// - Reset mid-REQ: rst_n=0 for one edge.
//   -> mem_wr_req=0 and all outputs 0 next cycle; no st_done; a new request then succeeds.
// - Macro on, TIMEOUT=16, ack never comes.
//   -> mem_wr_req drops after 16 REQ cycles; st_done+st_err pulse once.

Source files
------------

// File: rtl/mem_store_ctrl.sv
// Store-side memory write controller: aligns one store to byte lanes, runs a req/ack write, pulses st_done.
// Accept-to-req 1 cycle, zero-wait ack returns to IDLE in 3; optional req timeout under STORE_TIMEOUT_EN.
module mem_store_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_req,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   input  logic [1:0]        st_size,
   output logic              st_busy,
   output logic              st_done,
   output logic              st_misalign,
   output logic              st_err,
   output logic              mem_wr_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      FAIL = 2'd3
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [3:0]        be;
   } wr_req_t;

   state_t  state, state_nxt;
   wr_req_t wr_q, lane_req;
   logic    req_q, req_nxt;
   logic    capture;
   logic    legal;
   logic    expire;
   logic    tmo_abort;

   // Lane steering of the incoming request, evaluated only when captured in IDLE.
   always_comb begin
      lane_req       = '0;
      legal          = 1'b0;
      lane_req.addr  = {st_addr[ADDR_W-1:2], 2'b00};
      case (st_size)
         2'b00: begin
            lane_req.wdata = {4{st_data[7:0]}};
            lane_req.be    = 4'b0001 << st_addr[1:0];
            legal          = 1'b1;
         end
         2'b01: begin
            lane_req.wdata = {2{st_data[15:0]}};
            lane_req.be    = st_addr[1] ? 4'b1100 : 4'b0011;
            legal          = ~st_addr[0];
         end
         2'b10: begin
            lane_req.wdata = st_data;
            lane_req.be    = 4'b1111;
            legal          = (st_addr[1:0] == 2'b00);
         end
         default: legal = 1'b0;
      endcase
   end

`ifdef STORE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT);
   logic [CNT_W-1:0] tmo_cnt;
   logic             err_q;

   assign expire = (tmo_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state == REQ && req_q) tmo_cnt <= tmo_cnt + 1'b1;
         else                       tmo_cnt <= '0;
         err_q <= tmo_abort;
      end
   end

   assign st_err = (state == DONE) && err_q;
`else
   assign expire = 1'b0;
   assign st_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         req_q <= 1'b0;
         wr_q  <= '0;
      end else begin
         state <= state_nxt;
         req_q <= req_nxt;
         if (capture) wr_q <= lane_req;
      end
   end

   // The first REQ cycle only launches the registered request; ack counts once req is visible.
   always_comb begin
      state_nxt   = state;
      req_nxt     = req_q;
      capture     = 1'b0;
      tmo_abort   = 1'b0;
      st_done     = 1'b0;
      st_misalign = 1'b0;
      case (state)
         IDLE: begin
            req_nxt = 1'b0;
            if (st_req) begin
               capture   = 1'b1;
               state_nxt = legal ? REQ : FAIL;
            end
         end
         REQ: begin
            if (!req_q) begin
               req_nxt = 1'b1;
            end else if (mem_ack) begin
               req_nxt   = 1'b0;
               state_nxt = DONE;
            end else if (expire) begin
               req_nxt   = 1'b0;
               tmo_abort = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            st_done   = 1'b1;
            req_nxt   = 1'b0;
            state_nxt = IDLE;
         end
         FAIL: begin
            st_done     = 1'b1;
            st_misalign = 1'b1;
            req_nxt     = 1'b0;
            state_nxt   = IDLE;
         end
         default: begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign st_busy    = (state != IDLE);
   assign mem_wr_req = req_q;
   assign mem_addr   = wr_q.addr;
   assign mem_wdata  = wr_q.wdata;
   assign mem_be     = wr_q.be;

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Directed and randomized bench for mem_store_ctrl against a lane/timing reference model.
module tb_mem_store_ctrl;
   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 16;
`ifdef STORE_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              st_req = 1'b0;
   logic [ADDR_W-1:0] st_addr = '0;
   logic [31:0]       st_data = '0;
   logic [1:0]        st_size = '0;
   logic              st_busy, st_done, st_misalign, st_err;
   logic              mem_wr_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic              mem_ack = 1'b0;

   int n_asrt = 0;
   int n_fail = 0;

   mem_store_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
      .st_busy(st_busy), .st_done(st_done), .st_misalign(st_misalign), .st_err(st_err),
      .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: what memory should see for a store, from the lane rules in plain arithmetic.
   function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                                 output bit mis, output logic [31:0] ea, output logic [31:0] ew,
                                 output logic [3:0] eb);
      ea  = a - (a % 4);
      mis = 1'b0;
      ew  = '0;
      eb  = '0;
      case (sz)
         2'd0: begin ew = (d & 32'hFF) * 32'h01010101; eb = 4'(1 << (a % 4)); end
         2'd1: begin ew = (d & 32'hFFFF) * 32'h00010001; eb = ((a % 4) >= 2) ? 4'hC : 4'h3;
                     mis = (a % 2) != 0; end
         2'd2: begin ew = d; eb = 4'hF; mis = (a % 4) != 0; end
         default: mis = 1'b1;
      endcase
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},  {63'd0, st_busy}, 64'd0);
      chk({tag, "_done"},  {63'd0, st_done}, 64'd0);
      chk({tag, "_mis"},   {63'd0, st_misalign}, 64'd0);
      chk({tag, "_err"},   {63'd0, st_err}, 64'd0);
      chk({tag, "_req"},   {63'd0, mem_wr_req}, 64'd0);
      chk({tag, "_addr"},  {32'd0, mem_addr}, 64'd0);
      chk({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
      chk({tag, "_be"},    {60'd0, mem_be}, 64'd0);
   endtask

   // One store from IDLE back to IDLE; dly = ack offset in req-visible cycles.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input int dly, input bit noise);
      bit          mis, exp_err;
      logic [31:0] ea, ew;
      logic [3:0]  eb;
      int          nreq;
      model(a, d, sz, mis, ea, ew, eb);
      exp_err = TMO_ON && (dly >= TIMEOUT);
      nreq    = exp_err ? TIMEOUT : dly + 1;
      st_req = 1'b1; st_addr = a; st_data = d; st_size = sz;
      tick();
      st_req  = noise;
      st_data = 32'h11111111;
      st_addr = $urandom;
      st_size = 2'($urandom);
      if (mis) begin
         chk("fail_done", {63'd0, st_done}, 64'd1);
         chk("fail_mis",  {63'd0, st_misalign}, 64'd1);
         chk("fail_req",  {63'd0, mem_wr_req}, 64'd0);
         chk("fail_err",  {63'd0, st_err}, 64'd0);
      end else begin
         chk("launch_req",  {63'd0, mem_wr_req}, 64'd0);
         chk("launch_busy", {63'd0, st_busy}, 64'd1);
         tick();
         for (int k = 0; k < nreq; k++) begin
            chk("req_hi",    {63'd0, mem_wr_req}, 64'd1);
            chk("req_addr",  {32'd0, mem_addr}, {32'd0, ea});
            chk("req_wdata", {32'd0, mem_wdata}, {32'd0, ew});
            chk("req_be",    {60'd0, mem_be}, {60'd0, eb});
            chk("req_nodone", {63'd0, st_done}, 64'd0);
            mem_ack = (k == dly);
            tick();
            mem_ack = 1'b0;
         end
         chk("done",     {63'd0, st_done}, 64'd1);
         chk("done_req", {63'd0, mem_wr_req}, 64'd0);
         chk("done_mis", {63'd0, st_misalign}, 64'd0);
         chk("done_err", {63'd0, st_err}, {63'd0, exp_err});
      end
      st_req = noise;
      tick();
      st_req = 1'b0;
      chk("idle_busy", {63'd0, st_busy}, 64'd0);
      chk("idle_done", {63'd0, st_done}, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Directed cases.
      do_store(32'h100, 32'hDEADBEEF, 2'b10, 3, 1'b0);
      do_store(32'h203, 32'h000000A5, 2'b00, 0, 1'b0);
      do_store(32'h101, 32'h0000CAFE, 2'b01, 0, 1'b0);
      do_store(32'h102, 32'h12345678, 2'b10, 0, 1'b0);
      do_store(32'h0FC, 32'h00001234, 2'b11, 0, 1'b1);
      do_store(32'h402, 32'hABCD5678, 2'b01, 2, 1'b0);
      do_store(32'h500, 32'hCAFEF00D, 2'b10, 2, 1'b1);

      // Ack in idle must be ignored.
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("idle_ack_busy", {63'd0, st_busy}, 64'd0);
      chk("idle_ack_done", {63'd0, st_done}, 64'd0);

      // Reset in the middle of a request.
      st_req = 1'b1; st_addr = 32'h300; st_data = 32'h55AA55AA; st_size = 2'b10;
      tick();
      st_req = 1'b0;
      tick();
      chk("midrst_pre_req", {63'd0, mem_wr_req}, 64'd1);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_all_zero("midrst");
      tick();
      chk("midrst_nodone", {63'd0, st_done}, 64'd0);
      chk("midrst_idle",   {63'd0, st_busy}, 64'd0);
      do_store(32'h304, 32'h0BADF00D, 2'b10, 1, 1'b0);

      // Long stall: times out with the macro, waits it out without.
      do_store(32'h600, 32'h87654321, 2'b10, TIMEOUT + 4, 1'b0);
      if (TMO_ON) do_store(32'h604, 32'h0F0F0F0F, 2'b10, TIMEOUT - 1, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         do_store($urandom_range(0, 32'hFFFF), $urandom, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
